// File: rtl/ex_mem_pkg.sv
// Shared bus widths, control encodings and the EX/MEM slot record for the EX/MEM pipeline register.
package ex_mem_pkg;

   localparam int unsigned RegBus       = 32;
   localparam int unsigned RegAddrBus   = 5;
   localparam int unsigned AluOpBus     = 8;
   localparam int unsigned DoubleRegBus = 64;

   localparam logic Stop           = 1'b1;
   localparam logic NoStop         = 1'b0;
   localparam logic RstEnable      = 1'b0;
   localparam logic WriteDisable   = 1'b0;
   localparam logic NotInDelaySlot = 1'b0;

   localparam logic [RegBus-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
   localparam logic [AluOpBus-1:0]   EXE_NOP_OP = 8'b0000_0000;
   localparam logic [AluOpBus-1:0]   EXE_SW_OP  = 8'b1010_1011;

   localparam int unsigned StallExMem = 3;
   localparam int unsigned StallMem   = 4;

   typedef struct packed {
      logic [RegAddrBus-1:0] wd;
      logic                  wreg;
      logic [RegBus-1:0]     wdata;
      logic [RegBus-1:0]     hi;
      logic [RegBus-1:0]     lo;
      logic                  whilo;
      logic [AluOpBus-1:0]   aluop;
      logic [RegBus-1:0]     mem_addr;
      logic [RegBus-1:0]     reg2;
      logic                  cp0_reg_we;
      logic [4:0]            cp0_reg_write_addr;
      logic [RegBus-1:0]     cp0_reg_data;
      logic [31:0]           excepttype;
      logic                  is_in_delayslot;
      logic [RegBus-1:0]     current_inst_address;
   } mem_slot_t;

   // Contents of an empty slot: nothing is written anywhere downstream.
   function automatic mem_slot_t bubble_slot();
      mem_slot_t s;
      s.wd                   = NOPRegAddr;
      s.wreg                 = WriteDisable;
      s.wdata                = ZeroWord;
      s.hi                   = ZeroWord;
      s.lo                   = ZeroWord;
      s.whilo                = WriteDisable;
      s.aluop                = EXE_NOP_OP;
      s.mem_addr             = ZeroWord;
      s.reg2                 = ZeroWord;
      s.cp0_reg_we           = WriteDisable;
      s.cp0_reg_write_addr   = 5'b00000;
      s.cp0_reg_data         = ZeroWord;
      s.excepttype           = ZeroWord;
      s.is_in_delayslot      = NotInDelaySlot;
      s.current_inst_address = ZeroWord;
      return s;
   endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: advances, bubbles, holds or flushes the slot and keeps the
// MADD/MSUB partial product and cycle count looping back to EX while EX is stalled.
module ex_mem
   import ex_mem_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [5:0]              stall,
   input  logic                    flush,
   input  logic [RegAddrBus-1:0]   ex_wd,
   input  logic                    ex_wreg,
   input  logic [RegBus-1:0]       ex_wdata,
   input  logic [RegBus-1:0]       ex_hi,
   input  logic [RegBus-1:0]       ex_lo,
   input  logic                    ex_whilo,
   input  logic [AluOpBus-1:0]     ex_aluop,
   input  logic [RegBus-1:0]       ex_mem_addr,
   input  logic [RegBus-1:0]       ex_reg2,
   input  logic                    ex_cp0_reg_we,
   input  logic [4:0]              ex_cp0_reg_write_addr,
   input  logic [RegBus-1:0]       ex_cp0_reg_data,
   input  logic [31:0]             ex_excepttype,
   input  logic                    ex_is_in_delayslot,
   input  logic [RegBus-1:0]       ex_current_inst_address,
   input  logic [DoubleRegBus-1:0] hilo_i,
   input  logic [1:0]              cnt_i,
   output logic [RegAddrBus-1:0]   mem_wd,
   output logic                    mem_wreg,
   output logic [RegBus-1:0]       mem_wdata,
   output logic [RegBus-1:0]       mem_hi,
   output logic [RegBus-1:0]       mem_lo,
   output logic                    mem_whilo,
   output logic [AluOpBus-1:0]     mem_aluop,
   output logic [RegBus-1:0]       mem_mem_addr,
   output logic [RegBus-1:0]       mem_reg2,
   output logic                    mem_cp0_reg_we,
   output logic [4:0]              mem_cp0_reg_write_addr,
   output logic [RegBus-1:0]       mem_cp0_reg_data,
   output logic [31:0]             mem_excepttype,
   output logic                    mem_is_in_delayslot,
   output logic [RegBus-1:0]       mem_current_inst_address,
   output logic [DoubleRegBus-1:0] hilo_o,
   output logic [1:0]              cnt_o
);

   mem_slot_t              slot_q;
   mem_slot_t              ex_slot;
   logic [DoubleRegBus-1:0] hilo_q;
   logic [1:0]              cnt_q;

   // Only the EX/MEM and MEM stall bits matter to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   always_comb begin
      ex_slot.wd                   = ex_wd;
      ex_slot.wreg                 = ex_wreg;
      ex_slot.wdata                = ex_wdata;
      ex_slot.hi                   = ex_hi;
      ex_slot.lo                   = ex_lo;
      ex_slot.whilo                = ex_whilo;
      ex_slot.aluop                = ex_aluop;
      ex_slot.mem_addr             = ex_mem_addr;
      ex_slot.reg2                 = ex_reg2;
      ex_slot.cp0_reg_we           = ex_cp0_reg_we;
      ex_slot.cp0_reg_write_addr   = ex_cp0_reg_write_addr;
      ex_slot.cp0_reg_data         = ex_cp0_reg_data;
      ex_slot.excepttype           = ex_excepttype;
      ex_slot.is_in_delayslot      = ex_is_in_delayslot;
      ex_slot.current_inst_address = ex_current_inst_address;
   end

   always_ff @(posedge clk) begin
      if (rst_n == RstEnable) begin
         slot_q <= bubble_slot();
         hilo_q <= '0;
         cnt_q  <= 2'b00;
      end else if (flush) begin
         slot_q <= bubble_slot();
         hilo_q <= '0;
         cnt_q  <= 2'b00;
      end else if (stall[StallExMem] == Stop && stall[StallMem] == NoStop) begin
         // EX is iterating a MADD/MSUB: keep its partial product alive while MEM drains.
         slot_q <= bubble_slot();
         hilo_q <= hilo_i;
         cnt_q  <= cnt_i;
      end else if (stall[StallExMem] == NoStop) begin
         slot_q <= ex_slot;
         hilo_q <= '0;
         cnt_q  <= 2'b00;
      end
   end

   assign mem_wd                   = slot_q.wd;
   assign mem_wreg                 = slot_q.wreg;
   assign mem_wdata                = slot_q.wdata;
   assign mem_hi                   = slot_q.hi;
   assign mem_lo                   = slot_q.lo;
   assign mem_whilo                = slot_q.whilo;
   assign mem_aluop                = slot_q.aluop;
   assign mem_mem_addr             = slot_q.mem_addr;
   assign mem_reg2                 = slot_q.reg2;
   assign mem_cp0_reg_we           = slot_q.cp0_reg_we;
   assign mem_cp0_reg_write_addr   = slot_q.cp0_reg_write_addr;
   assign mem_cp0_reg_data         = slot_q.cp0_reg_data;
   assign mem_excepttype           = slot_q.excepttype;
   assign mem_is_in_delayslot      = slot_q.is_in_delayslot;
   assign mem_current_inst_address = slot_q.current_inst_address;
   assign hilo_o                   = hilo_q;
   assign cnt_o                    = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem: reset, advance, MADD bubble, hold, flush, store path.
module tb_ex_mem;
   import ex_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  stall;
   logic        flush;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata, ex_hi, ex_lo;
   logic        ex_whilo;
   logic [7:0]  ex_aluop;
   logic [31:0] ex_mem_addr, ex_reg2;
   logic        ex_cp0_reg_we;
   logic [4:0]  ex_cp0_reg_write_addr;
   logic [31:0] ex_cp0_reg_data, ex_excepttype;
   logic        ex_is_in_delayslot;
   logic [31:0] ex_current_inst_address;
   logic [63:0] hilo_i;
   logic [1:0]  cnt_i;

   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata, mem_hi, mem_lo;
   logic        mem_whilo;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr, mem_reg2;
   logic        mem_cp0_reg_we;
   logic [4:0]  mem_cp0_reg_write_addr;
   logic [31:0] mem_cp0_reg_data, mem_excepttype;
   logic        mem_is_in_delayslot;
   logic [31:0] mem_current_inst_address;
   logic [63:0] hilo_o;
   logic [1:0]  cnt_o;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   ex_mem dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
      .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .ex_cp0_reg_we(ex_cp0_reg_we), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
      .ex_cp0_reg_data(ex_cp0_reg_data), .ex_excepttype(ex_excepttype),
      .ex_is_in_delayslot(ex_is_in_delayslot),
      .ex_current_inst_address(ex_current_inst_address),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
      .mem_cp0_reg_data(mem_cp0_reg_data), .mem_excepttype(mem_excepttype),
      .mem_is_in_delayslot(mem_is_in_delayslot),
      .mem_current_inst_address(mem_current_inst_address),
      .hilo_o(hilo_o), .cnt_o(cnt_o)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Apply inputs, take one rising edge, come back to the falling edge to sample.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_ex();
      ex_wd = '0; ex_wreg = 0; ex_wdata = '0; ex_hi = '0; ex_lo = '0; ex_whilo = 0;
      ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0; ex_cp0_reg_we = 0;
      ex_cp0_reg_write_addr = '0; ex_cp0_reg_data = '0; ex_excepttype = '0;
      ex_is_in_delayslot = 0; ex_current_inst_address = '0; hilo_i = '0; cnt_i = '0;
   endtask

   initial begin
      rst_n = 0; stall = '0; flush = 0;
      clear_ex();
      @(negedge clk);

      // Reset while EX presents a live write
      ex_wdata = 32'hDEADBEEF; ex_wreg = 1; ex_wd = 5'd9; hilo_i = 64'h55; cnt_i = 2'b01;
      step();
      check("rst_wdata", mem_wdata, 0);
      check("rst_wreg",  mem_wreg,  0);
      check("rst_wd",    mem_wd,    0);
      check("rst_cnt",   cnt_o,     0);
      check("rst_hilo",  hilo_o,    0);

      // Advance: basic GPR write, hilo feedback cleared
      rst_n = 1; clear_ex();
      ex_wd = 5'd3; ex_wdata = 32'h1234; ex_wreg = 1; hilo_i = 64'hABCD; cnt_i = 2'b10;
      step();
      check("adv_wd",    mem_wd,    3);
      check("adv_wdata", mem_wdata, 32'h1234);
      check("adv_wreg",  mem_wreg,  1);
      check("adv_hilo",  hilo_o,    0);
      check("adv_cnt",   cnt_o,     0);

      // Advance with every other field populated
      clear_ex();
      ex_hi = 32'h1111_2222; ex_lo = 32'h3333_4444; ex_whilo = 1;
      ex_cp0_reg_we = 1; ex_cp0_reg_write_addr = 5'd12; ex_cp0_reg_data = 32'hC0C0;
      ex_excepttype = 32'h200; ex_is_in_delayslot = 1; ex_current_inst_address = 32'hBFC0_0010;
      step();
      check("adv_hi",    mem_hi,    32'h1111_2222);
      check("adv_lo",    mem_lo,    32'h3333_4444);
      check("adv_whilo", mem_whilo, 1);
      check("adv_cp0we", mem_cp0_reg_we, 1);
      check("adv_cp0a",  mem_cp0_reg_write_addr, 12);
      check("adv_cp0d",  mem_cp0_reg_data, 32'hC0C0);
      check("adv_exc",   mem_excepttype, 32'h200);
      check("adv_ds",    mem_is_in_delayslot, 1);
      check("adv_pc",    mem_current_inst_address, 32'hBFC0_0010);

      // MADD bubble: slot cleared, partial product captured
      clear_ex();
      stall = 6'b001111; ex_wd = 5'd7; ex_wreg = 1; ex_wdata = 32'h77;
      hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
      step();
      check("madd_wreg", mem_wreg,  0);
      check("madd_wd",   mem_wd,    0);
      check("madd_ds",   mem_is_in_delayslot, 0);
      check("madd_hilo", hilo_o,    64'h0000_0001_0000_0002);
      check("madd_cnt",  cnt_o,     1);
      stall = 6'b000000; hilo_i = 64'h9999; cnt_i = 2'b10;
      step();
      check("madd_rel_cnt",   cnt_o,     0);
      check("madd_rel_hilo",  hilo_o,    0);
      check("madd_rel_wd",    mem_wd,    7);
      check("madd_rel_wdata", mem_wdata, 32'h77);
      check("madd_rel_wreg",  mem_wreg,  1);

      // Hold: slot and loop-back both frozen, EX ignored
      clear_ex(); ex_wdata = 32'hA5A5; ex_wreg = 1;
      step();
      check("hold_load", mem_wdata, 32'hA5A5);
      ex_wdata = 32'hFFFF; ex_wreg = 0; stall = 6'b011111;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_wdata", mem_wdata, 32'hA5A5);
         check("hold_wreg",  mem_wreg,  1);
      end
      stall = 6'b001111; hilo_i = 64'hFEED_0000_BEEF; cnt_i = 2'b10;
      step();
      stall = 6'b011111; hilo_i = 64'h1; cnt_i = 2'b01;
      step();
      check("hold_hilo", hilo_o, 64'hFEED_0000_BEEF);
      check("hold_cnt",  cnt_o,  2);

      // Flush beats stall
      flush = 1; stall = 6'b001111; ex_excepttype = 32'h8; ex_wreg = 1;
      hilo_i = 64'h1234; cnt_i = 2'b01;
      step();
      check("flush_exc",  mem_excepttype, 0);
      check("flush_wreg", mem_wreg, 0);
      check("flush_cnt",  cnt_o, 0);
      check("flush_hilo", hilo_o, 0);
      flush = 0; stall = '0;

      // Store path
      clear_ex();
      ex_aluop = EXE_SW_OP; ex_mem_addr = 32'h100; ex_reg2 = 32'h55;
      step();
      check("sw_aluop", mem_aluop, 8'hAB);
      check("sw_addr",  mem_mem_addr, 32'h100);
      check("sw_reg2",  mem_reg2, 32'h55);

      // Reset in the middle of a MADD sequence discards the partial product
      clear_ex(); stall = 6'b001111; hilo_i = 64'h42; cnt_i = 2'b01;
      step();
      check("mid_cnt", cnt_o, 1);
      rst_n = 0;
      step();
      check("mid_rst_cnt",   cnt_o,  0);
      check("mid_rst_hilo",  hilo_o, 0);
      check("mid_rst_aluop", mem_aluop, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
